// File: rtl/isqrt_share_arbiter.sv
// Purpose : shares one pipelined isqrt between N_REQ requesters; round-robin grant,
//           in-order tag FIFO routes each result back to the requester that issued it.
// Latency : zero cycles both ways (request and result paths are combinational); end-to-end = isqrt latency.
// Backpressure: req_x_rdy is withheld while the tag FIFO is full, unless a result pops that same cycle.
// Ports   : clk/rst (sync, active-high); req_x_vld/req_x/req_x_rdy (operands in);
//           req_y_vld/req_y (results out); isqrt_x_vld/isqrt_x, isqrt_y_vld/isqrt_y (shared unit);
//           inflight (ops issued, not yet returned); err (sticky: result arrived with FIFO empty).
module isqrt_share_arbiter #(
   parameter int N_REQ        = 2,
   parameter int MAX_INFLIGHT = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [N_REQ-1:0]                req_x_vld,
   input  logic [N_REQ*32-1:0]             req_x,
   output logic [N_REQ-1:0]                req_x_rdy,
   output logic [N_REQ-1:0]                req_y_vld,
   output logic [15:0]                     req_y,
   output logic                            isqrt_x_vld,
   output logic [31:0]                     isqrt_x,
   input  logic                            isqrt_y_vld,
   input  logic [15:0]                     isqrt_y,
   output logic [$clog2(MAX_INFLIGHT):0]   inflight,
   output logic                            err
);

   localparam int TW = $clog2(N_REQ);
   localparam int PW = $clog2(MAX_INFLIGHT);
   localparam int CW = PW + 1;

   logic [TW-1:0] tags [MAX_INFLIGHT];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [TW-1:0] last;

   logic          can_issue;
   logic          grant;
   logic [TW-1:0] winner;
   logic          empty;
   logic          pop;
   logic [TW-1:0] head;

   // Index of the k-th requester after base, wrapping at N_REQ (N_REQ need not be a power of two).
   function automatic logic [TW-1:0] rr_idx(input logic [TW-1:0] base, input int k);
      return TW'((int'(base) + k) % N_REQ);
   endfunction

   assign empty     = (count == '0);
   assign head      = tags[rd_ptr];
   assign pop       = isqrt_y_vld && !empty;
   // A result popping this cycle frees a slot, so a full FIFO can still accept a grant.
   assign can_issue = (count < CW'(MAX_INFLIGHT)) || isqrt_y_vld;

   // Round-robin scan beginning just after the last winner.
   always_comb begin
      grant  = 1'b0;
      winner = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (can_issue && !grant && req_x_vld[rr_idx(last, k)]) begin
            grant  = 1'b1;
            winner = rr_idx(last, k);
         end
      end
   end

   always_comb begin
      req_x_rdy = '0;
      if (grant) req_x_rdy[winner] = 1'b1;
   end

   // Operand is don't-care without a grant; the winner mux output is passed regardless.
   assign isqrt_x_vld = grant;
   assign isqrt_x     = req_x[32*int'(winner) +: 32];

   always_comb begin
      req_y_vld = '0;
      if (pop) req_y_vld[head] = 1'b1;
   end

   assign req_y    = isqrt_y;
   assign inflight = count;

   // Tag storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge clk) begin
      if (grant) tags[wr_ptr] <= winner;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last   <= TW'(N_REQ - 1);
         err    <= 1'b0;
      end else begin
         if (grant) begin
            wr_ptr <= wr_ptr + PW'(1);
            last   <= winner;
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({grant, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (isqrt_y_vld && empty) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_isqrt_share_arbiter.sv
// Bench for isqrt_share_arbiter with 3 requesters, 4-deep tag FIFO and a
// behavioural isqrt whose latency can be changed between reset-separated tests.
// A per-cycle monitor predicts grants/results from the stimulus alone.
module tb_isqrt_share_arbiter;
   localparam int N = 3;
   localparam int M = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst = 1'b1;
   logic [N-1:0]    rv = '0;
   logic [31:0]     ops [N];
   logic [N*32-1:0] req_x;
   logic [N-1:0]    req_x_rdy;
   logic [N-1:0]    req_y_vld;
   logic [15:0]     req_y;
   logic            isqrt_x_vld;
   logic [31:0]     isqrt_x;
   logic            isqrt_y_vld;
   logic [15:0]     isqrt_y;
   logic [2:0]      inflight;
   logic            err;
   logic            force_vld = 1'b0;
   int              lat = 4;
   int              total = 0;
   int              bad = 0;

   assign req_x = {ops[2], ops[1], ops[0]};

   isqrt_share_arbiter #(.N_REQ(N), .MAX_INFLIGHT(M)) dut (
      .clk(clk), .rst(rst),
      .req_x_vld(rv), .req_x(req_x), .req_x_rdy(req_x_rdy),
      .req_y_vld(req_y_vld), .req_y(req_y),
      .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
      .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y),
      .inflight(inflight), .err(err)
   );

   function automatic logic [15:0] root(input logic [31:0] x);
      logic [15:0] r;
      logic [15:0] t;
      longint unsigned tt;
      r = '0;
      for (int b = 15; b >= 0; b--) begin
         t  = r | (16'd1 << b);
         tt = longint'(t);
         if (tt * tt <= longint'(x)) r = t;
      end
      return r;
   endfunction

   // Behavioural isqrt: result of a cycle-c operand is visible in cycle c+lat.
   logic        pv [16];
   logic [15:0] py [16];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) pv[i] <= 1'b0;
      end else begin
         pv[0] <= isqrt_x_vld;
         py[0] <= root(isqrt_x);
         for (int i = 1; i < 16; i++) begin
            pv[i] <= pv[i-1];
            py[i] <= py[i-1];
         end
      end
   end
   assign isqrt_y_vld = pv[lat-1] | force_vld;
   assign isqrt_y     = force_vld ? 16'hDEAD : py[lat-1];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, req, $time);
      end
   endtask

   // Scoreboard / reference model
   typedef struct {int tag; logic [15:0] y;} exp_t;
   exp_t         sb[$];
   int           cnt_m = 0;
   int           last_m = N - 1;
   logic         err_m = 1'b0;
   logic [N-1:0] rdy_hist[$];
   int           infl_max = 0;

   task automatic monitor_step();
      logic [N-1:0] e_rdy;
      logic [N-1:0] e_yv;
      int           win;
      exp_t         e;
      if (rst) begin
         cnt_m = 0; last_m = N - 1; err_m = 1'b0; sb.delete();
      end else begin
         e_rdy = '0;
         win   = -1;
         if (cnt_m < M || isqrt_y_vld)
            for (int k = 1; k <= N; k++)
               if (win < 0 && rv[(last_m + k) % N]) win = (last_m + k) % N;
         if (win >= 0) e_rdy[win] = 1'b1;
         chk("mon_grant", 64'(req_x_rdy), 64'(e_rdy));
         chk("mon_x_vld", 64'(isqrt_x_vld), 64'(win >= 0));
         if (win >= 0) chk("mon_x_data", 64'(isqrt_x), 64'(ops[win]));
         e_yv = '0;
         if (isqrt_y_vld && sb.size() > 0) begin
            e = sb.pop_front();
            e_yv[e.tag] = 1'b1;
            chk("mon_y_data", 64'(req_y), 64'(e.y));
         end
         chk("mon_y_vld", 64'(req_y_vld), 64'(e_yv));
         chk("mon_inflight", 64'(inflight), 64'(cnt_m));
         chk("mon_err", 64'(err), 64'(err_m));
         rdy_hist.push_back(req_x_rdy);
         if (int'(inflight) > infl_max) infl_max = int'(inflight);
         if (isqrt_y_vld && e_yv == '0) err_m = 1'b1;
         if (e_yv != '0) cnt_m--;
         if (win >= 0) begin
            cnt_m++;
            last_m = win;
            e.tag  = win;
            e.y    = root(ops[win]);
            sb.push_back(e);
         end
      end
   endtask

   initial forever begin
      @(negedge clk);
      monitor_step();
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   typedef struct {int r; logic [31:0] x; logic [15:0] y;} vec_t;
   vec_t tv [7];

   initial begin
      int n;
      int g [N];
      tv[0] = '{1, 32'd144,        16'd12};
      tv[1] = '{0, 32'd0,          16'd0};
      tv[2] = '{2, 32'd1,          16'd1};
      tv[3] = '{0, 32'hFFFF_FFFF,  16'hFFFF};
      tv[4] = '{1, 32'd15,         16'd3};
      tv[5] = '{2, 32'd1000000,    16'd1000};
      tv[6] = '{0, 32'd2,          16'd1};
      for (int i = 0; i < N; i++) ops[i] = '0;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_inflight", 64'(inflight), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_y_vld", 64'(req_y_vld), 64'd0);
      chk("rst_x_vld", 64'(isqrt_x_vld), 64'd0);

      // Single requests from the table, one at a time
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         ops[tv[i].r] = tv[i].x;
         rv[tv[i].r]  = 1'b1;
         @(negedge clk);
         chk("tv_grant", 64'(req_x_rdy), 64'(1 << tv[i].r));
         @(posedge clk); #1 rv = '0;
         n = 0;
         do begin @(negedge clk); n++; end while (req_y_vld == '0 && n < 20);
         chk("tv_latency", 64'(n), 64'(lat));
         chk("tv_route", 64'(req_y_vld), 64'(1 << tv[i].r));
         chk("tv_root", 64'(req_y), 64'(tv[i].y));
         chk("tv_inflight_busy", 64'(inflight), 64'd1);
         @(negedge clk);
         chk("tv_inflight_idle", 64'(inflight), 64'd0);
      end

      // Contention: both hold valid, 0 then 1
      do_reset();
      ops[0] = 32'd16; ops[1] = 32'd81; rv = 3'b011;
      @(negedge clk); chk("ct_g0", 64'(req_x_rdy), 64'b001);
      @(posedge clk); #1 rv[0] = 1'b0;
      @(negedge clk); chk("ct_g1", 64'(req_x_rdy), 64'b010);
      @(posedge clk); #1 rv[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk("ct_r0_vld", 64'(req_y_vld), 64'b001);
      chk("ct_r0_y", 64'(req_y), 64'd4);
      @(negedge clk);
      chk("ct_r1_vld", 64'(req_y_vld), 64'b010);
      chk("ct_r1_y", 64'(req_y), 64'd9);

      // Continuous round-robin over 30 cycles
      do_reset();
      ops[0] = 32'd49; ops[1] = 32'd64; ops[2] = 32'd10000; rv = 3'b111;
      rdy_hist.delete();
      repeat (30) @(negedge clk);
      @(posedge clk); #1 rv = '0;
      for (int i = 0; i < N; i++) g[i] = 0;
      for (int k = 0; k < 30; k++) begin
         chk("rr_seq", 64'(rdy_hist[k]), 64'(1 << (k % 3)));
         for (int i = 0; i < N; i++) if (rdy_hist[k][i]) g[i]++;
      end
      for (int i = 0; i < N; i++) chk("rr_count", 64'(g[i]), 64'd10);
      repeat (10) @(negedge clk);

      // Full FIFO with a slow isqrt
      lat = 8;
      do_reset();
      ops[0] = 32'd36; rv = 3'b001;
      rdy_hist.delete();
      infl_max = 0;
      repeat (9) @(negedge clk);
      @(posedge clk); #1 rv = '0;
      for (int k = 0; k < 9; k++)
         chk("ff_grant", 64'(rdy_hist[k][0]), 64'(k < 4 || k == 8));
      chk("ff_max_inflight", 64'(infl_max), 64'd4);
      repeat (12) @(negedge clk);

      // Reset mid-flight: requester 0 granted last, yet wins the tie afterwards
      lat = 4;
      do_reset();
      ops[0] = 32'd25; rv = 3'b001;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rv = '0; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rm_inflight", 64'(inflight), 64'd0);
      chk("rm_err", 64'(err), 64'd0);
      @(posedge clk); #1 ops[0] = 32'd4; ops[1] = 32'd9; rv = 3'b011;
      @(negedge clk); chk("rm_tie", 64'(req_x_rdy), 64'b001);
      @(posedge clk); #1 rv[0] = 1'b0;
      @(negedge clk); chk("rm_next", 64'(req_x_rdy), 64'b010);
      @(posedge clk); #1 rv = '0;
      repeat (8) @(negedge clk);

      // Spurious result with the FIFO empty
      do_reset();
      force_vld = 1'b1;
      @(negedge clk);
      chk("sp_no_y_vld", 64'(req_y_vld), 64'd0);
      chk("sp_err_before", 64'(err), 64'd0);
      @(posedge clk); #1 force_vld = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("sp_err_sticky", 64'(err), 64'd1);
      end
      do_reset();
      @(negedge clk);
      chk("sp_err_cleared", 64'(err), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
